axi_rd_burst_master: RTL
========================

Name: axi_rd_burst_master

Overview:
- Parametrised AXI4 read-burst engine used by the DMA/loader path to fetch tensors from external memory.
- Accepts one descriptor (start address, beat count) and splits it into AXI4 INCR bursts bounded by MAX_BURST and the 4 KB rule.
- Keeps up to MAX_OUTST bursts in flight and streams the returned data out on a valid/ready interface.
- Generalises the package's fixed 128-bit AXI4 channel definitions to any data width, ID width and burst depth.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 128, data width; power of two, 8..1024.
- ID_W, 4, AXI ID width.
- MAX_BURST, 16, maximum beats per burst, 1..256.
- MAX_OUTST, 4, maximum outstanding AR bursts, 1..16.
- ARID_VAL, 0, constant ARID driven on every burst.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  descriptor accepted; high only in IDLE.
- cmd_addr  in  ADDR_W  start byte address; must be aligned to DATA_W/8.
- cmd_beats  in  16  total beats requested.
- m_arid  out  ID_W  equals ARID_VAL.
- m_araddr  out  ADDR_W  burst address.
- m_arlen  out  8  burst beats minus 1.
- m_arsize  out  3  log2(DATA_W/8).
- m_arburst  out  2  always INCR (2'b01).
- m_arvalid  out  1  AR valid.
- m_arready  in  1  AR ready.
- m_rid  in  ID_W  ignored.
- m_rdata  in  DATA_W  read data.
- m_rresp  in  2  read response.
- m_rlast  in  1  last beat of burst.
- m_rvalid  in  1  R valid.
- m_rready  out  1  R ready.
- out_data  out  DATA_W  streamed data.
- out_valid  out  1  stream valid.
- out_last  out  1  final beat of the whole command.
- out_ready  in  1  stream ready.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  valid with done; set if any beat returned rresp[1]=1.

Behaviour:
- Reset (async on rst_n low; applies mid-operation too): FSM to IDLE; all counters, m_arvalid, done, err and busy to 0. cmd_ready=1 once out of reset. In-flight bursts are abandoned, not drained.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch addr/beats, clear the err accumulator, go to ISSUE; if cmd_beats==0, go to DONE instead.
  - ISSUE: compute blen = min(remaining AR beats, MAX_BURST, (4096 - addr[11:0]) >> log2(DATA_W/8)). Register m_araddr/m_arlen=blen-1 and assert m_arvalid, only while outst < MAX_OUTST. Hold all AR fields stable until m_arready. On handshake: addr += blen*DATA_W/8, remaining -= blen, outst++. When remaining AR beats reach 0, go to DRAIN.
  - DRAIN: wait until the rx beat counter reaches 0 and outst==0, then go to DONE.
  - DONE: assert done=1 for exactly one cycle, err = accumulated value, then return to IDLE.
- busy=1 in every state except IDLE.
- R path is a combinational passthrough: out_data=m_rdata, out_valid=m_rvalid, m_rready=out_ready while busy; m_rready=0 in IDLE.
- Each R handshake decrements the rx beat counter (loaded with cmd_beats at accept) and ORs rresp[1] into err.
- outst decrements on an R handshake with m_rlast=1. If an AR handshake and a rlast handshake occur in the same cycle, outst is unchanged.
- out_last = m_rvalid && rx counter==1.
- Burst splitting runs in parallel with R reception; the ISSUE state overlaps with data return.
- m_arlen is 8 bits; blen never exceeds 256.
- Boundary cases:
  - Misaligned cmd_addr: behaviour undefined; a bench assertion flags it.
  - cmd_beats==0: done pulses 2 cycles after accept with err=0; no AR is issued.
  - outst==MAX_OUTST: m_arvalid stays low until a rlast handshake frees a slot.

Test Plan:
- addr 0x1000, beats 4, DATA_W=128 -> one AR: araddr 0x1000, arlen 3, arsize 3'b100, arburst 01. 4 beats out, out_last on beat 4, done with err=0.
- addr 0x0, beats 40, MAX_BURST=16 -> ARs at 0x000/0x100/0x200 with arlen 15/15/7. 40 beats out, out_last only on beat 40.
- addr 0x0FC0, beats 8 -> ARs at 0x0FC0 arlen 3 and 0x1000 arlen 3; no burst crosses the 4 KB boundary.
- m_arready=1, m_rvalid=0, beats 128 -> exactly 4 ARs, then m_arvalid low. The 5th AR issues the cycle after the first rlast handshake.
- out_ready held low 5 cycles mid-burst -> m_rready low for those cycles, no beat lost or duplicated. Also: rresp=2'b10 on beat 3 of 4 -> done with err=1, and the next command reports err=0.
- rst_n asserted during DRAIN -> next cycle busy=0, m_arvalid=0, cmd_ready=1. A fresh 4-beat command then completes normally; cmd_beats=0 -> no AR, done pulse.

Source files
------------

// File: rtl/axi_rd_burst_master.sv
// -----------------------------------------------------------------------------
// axi_rd_burst_master
//   AXI4 read-burst engine. Takes one descriptor (start address, beat count),
//   splits it into INCR bursts limited by MAX_BURST and by 4 KB page edges,
//   keeps up to MAX_OUTST bursts outstanding and streams the returned beats
//   out on a valid/ready interface.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/ready/addr/beats    descriptor input (ready only while idle)
//   m_ar*                         AXI4 read-address channel (master side)
//   m_r*                          AXI4 read-data channel (master side)
//   out_data/valid/last/ready     output beat stream (last = final beat of cmd)
//   busy                          command in progress
//   done, err                     done pulses once per command; err holds the
//                                 OR of rresp[1] over that command's beats
// -----------------------------------------------------------------------------
module axi_rd_burst_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int ID_W      = 4,
    parameter int MAX_BURST = 16,
    parameter int MAX_OUTST = 4,
    parameter int ARID_VAL  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_beats,
    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int SIZE = $clog2(DATA_W / 8);
    localparam int OW   = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);
    localparam logic [16:0]   MAXB      = 17'(MAX_BURST);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_addr;        // address of the next burst to issue
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic [8:0]        r_blen;        // beat count of the burst on the AR bus
    logic              r_arvalid;
    logic [15:0]       r_ar_rem;      // beats not yet covered by an AR
    logic [15:0]       r_rx_cnt;      // beats not yet received
    logic [OW-1:0]     r_outst;
    logic              r_err_acc;
    logic              r_err;
    logic              r_done;

    logic              w_busy, w_cmd_ready, w_cmd_hs;
    logic              w_rready, w_r_hs, w_rlast_hs, w_ar_hs, w_ar_load;
    logic [12:0]       w_page_bytes, w_page_beats;
    logic [16:0]       w_blen_min;
    logic [8:0]        w_blen;
    logic              w_unused;

    // ---------------- FSM: next state and state-decoded outputs -------------
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_cmd_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy      = 1'b0;
                w_cmd_ready = 1'b1;
                if (cmd_valid)
                    w_state_next = (cmd_beats == 16'd0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                // Last AR accepted: everything left is data return.
                if (w_ar_hs && (r_ar_rem == 16'(r_blen)))
                    w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if ((r_rx_cnt == 16'd0) && (r_outst == '0))
                    w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_cmd_hs   = cmd_valid && w_cmd_ready;
    assign w_rready   = out_ready && w_busy;
    assign w_r_hs     = m_rvalid && w_rready;
    assign w_rlast_hs = w_r_hs && m_rlast;
    assign w_ar_hs    = r_arvalid && m_arready;

    // ---------------- burst length: min(remaining, MAX_BURST, page room) ----
    assign w_page_bytes = 13'd4096 - {1'b0, r_addr[11:0]};
    assign w_page_beats = w_page_bytes >> SIZE;

    always_comb begin
        w_blen_min = {1'b0, r_ar_rem};
        if (w_blen_min > MAXB)
            w_blen_min = MAXB;
        if (w_blen_min > {4'd0, w_page_beats})
            w_blen_min = {4'd0, w_page_beats};
    end
    assign w_blen = w_blen_min[8:0];

    // A slot freed by an rlast handshake this cycle is usable immediately, so
    // the next AR appears the cycle after the rlast handshake.
    assign w_ar_load = (r_state == S_ISSUE) && !r_arvalid && (r_ar_rem != 16'd0) &&
                       ((r_outst < OUTST_MAX) || w_rlast_hs);

    // ---------------- registers ---------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_blen    <= '0;
            r_arvalid <= 1'b0;
            r_ar_rem  <= '0;
            r_rx_cnt  <= '0;
            r_outst   <= '0;
            r_err_acc <= 1'b0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == S_DONE);
            if (r_state == S_DONE)
                r_err <= r_err_acc;

            if (w_cmd_hs) begin
                r_addr    <= cmd_addr;
                r_ar_rem  <= cmd_beats;
                r_rx_cnt  <= cmd_beats;
                r_err_acc <= 1'b0;
            end else if (w_r_hs) begin
                if (r_rx_cnt != 16'd0)
                    r_rx_cnt <= r_rx_cnt - 16'd1;
                if (m_rresp[1])
                    r_err_acc <= 1'b1;
            end

            // AR fields are captured once and held until the handshake.
            if (w_ar_load) begin
                r_araddr  <= r_addr;
                r_arlen   <= 8'(w_blen - 9'd1);
                r_blen    <= w_blen;
                r_arvalid <= 1'b1;
            end else if (w_ar_hs) begin
                r_arvalid <= 1'b0;
                r_addr    <= r_addr + (ADDR_W'(r_blen) << SIZE);
                r_ar_rem  <= r_ar_rem - 16'(r_blen);
            end

            case ({w_ar_hs, w_rlast_hs})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   if (r_outst != '0) r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // ---------------- outputs -----------------------------------------------
    assign cmd_ready = w_cmd_ready;
    assign busy      = w_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign m_arid    = ID_W'(ARID_VAL);
    assign m_araddr  = r_araddr;
    assign m_arlen   = r_arlen;
    assign m_arsize  = 3'(SIZE);
    assign m_arburst = 2'b01;
    assign m_arvalid = r_arvalid;
    assign m_rready  = w_rready;
    assign out_data  = m_rdata;
    assign out_valid = m_rvalid && w_busy;
    assign out_last  = m_rvalid && w_busy && (r_rx_cnt == 16'd1);

    assign w_unused = ^{m_rid, m_rresp[0], w_blen_min[16:9]};

endmodule
